led_step_sequencer: RTL and testbench

//  Consumes the square-wave output of the 3 s slow-clock divider and steps a
//  16-LED "fill" pattern once per slow-clock rising edge. Start, pause and

---
 rtl/led_step_sequencer.sv | 129 ++++++++++++
 tb/tb_led_step_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_step_sequencer
//  Description : Steps a 16-LED fill pattern once per rising edge of a slow
//                square wave that is sampled as data in the clk domain.
//                A four-state FSM handles start, pause, and completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_step_sequencer #(
    parameter int NUM_STEPS = 16,   // steps per run, 1..16
    parameter int DIR       = 0     // 0: fill from led[0] up, 1: from led[15] down
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slow_clk,
    input  logic        start,
    input  logic        en,
    output logic [15:0] led,
    output logic [4:0]  step,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] C_LAST_STEP = 5'(NUM_STEPS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_slow_d;
    logic [15:0] r_led;
    logic [15:0] w_led_nxt;
    logic [4:0]  r_step;
    logic [4:0]  w_step_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;

    logic        w_rise;
    logic [4:0]  w_step_inc;
    logic [15:0] w_step_bit;

    // slow_clk is plain data here; a rise is a 0->1 change between samples
    assign w_rise     = slow_clk & ~r_slow_d;
    assign w_step_inc = r_step + 5'd1;

    // One-hot LED for the step about to complete; r_step never reaches 16
    // while stepping because the run ends when it reaches NUM_STEPS.
    generate
        if (DIR == 0) begin : g_fill_up
            assign w_step_bit = 16'h0001 << r_step[3:0];
        end else begin : g_fill_down
            assign w_step_bit = 16'h8000 >> r_step[3:0];
        end
    endgenerate

    // State and output registers; edge-detect sample taken in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_slow_d <= 1'b0;
            r_led    <= 16'h0000;
            r_step   <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slow_d <= slow_clk;
            r_led    <= w_led_nxt;
            r_step   <= w_step_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; priority is start > en > rise
    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_step_nxt  = r_step;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_led_nxt   = 16'h0000;
                    w_step_nxt  = 5'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = en ? S_RUN : S_PAUSE;
                end
            end
            S_RUN: begin
                if (!en) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_rise) begin
                    w_step_nxt = w_step_inc;
                    w_led_nxt  = r_led | w_step_bit;
                    if (w_step_inc == C_LAST_STEP) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                // Rises seen while paused are dropped; resuming waits for a new one
                if (en) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign led  = r_led;
    assign step = r_step;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_step_sequencer
//  Description : Self-checking bench for led_step_sequencer. Two instances
//                (16 steps upward, 4 steps downward) share stimulus and are
//                compared against a count-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_step_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        slow_clk = 1'b0;
    logic        start    = 1'b0;
    logic        en       = 1'b0;
    logic [15:0] led_a, led_b;
    logic [4:0]  step_a, step_b;
    logic        busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;
    int dcnt_a = 0;
    int dcnt_b = 0;

    logic [22:0] act_v [2];
    logic [22:0] exp_v [2];

    always #5 clk = ~clk;

    led_step_sequencer #(.NUM_STEPS(16), .DIR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start(start), .en(en),
        .led(led_a), .step(step_a), .busy(busy_a), .done(done_a)
    );

    led_step_sequencer #(.NUM_STEPS(4), .DIR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start(start), .en(en),
        .led(led_b), .step(step_b), .busy(busy_b), .done(done_b)
    );

    assign act_v[0] = {led_a, step_a, busy_a, done_a};
    assign act_v[1] = {led_b, step_b, busy_b, done_b};

    // Fill pattern as a function of completed steps
    function automatic logic [15:0] fill(input int d, input int cnt);
        logic [31:0] t;
        if (d == 0) t = (32'd1 << cnt) - 32'd1;
        else        t = ~(32'h0000_FFFF >> cnt);
        return t[15:0];
    endfunction

    // Reference model: a step count plus run mode per instance
    for (genvar k = 0; k < 2; k++) begin : g_model
        localparam int N = (k == 0) ? 16 : 4;
        localparam int D = (k == 0) ? 0 : 1;
        int   st;
        int   n;
        logic sd;
        logic dn;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st <= M_IDLE; n <= 0; sd <= 1'b0; dn <= 1'b0;
            end else begin
                sd <= slow_clk;
                dn <= 1'b0;
                if ((st == M_IDLE || st == M_DONE) && start) begin
                    n  <= 0;
                    st <= en ? M_RUN : M_PAUSE;
                end else if (st == M_RUN && !en) begin
                    st <= M_PAUSE;
                end else if (st == M_RUN && slow_clk && !sd) begin
                    n <= n + 1;
                    if (n + 1 == N) begin
                        st <= M_DONE;
                        dn <= 1'b1;
                    end
                end else if (st == M_PAUSE && en) begin
                    st <= M_RUN;
                end
            end
        end
        assign exp_v[k] = {fill(D, n), 5'(n), (st == M_RUN || st == M_PAUSE), dn};
    end

    always @(negedge clk) begin
        if (done_a === 1'b1) dcnt_a++;
        if (done_b === 1'b1) dcnt_b++;
    end

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; en = 1'b0; slow_clk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic e);
        en = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rise(input logic e);
        en = e; slow_clk = 1'b0;
        repeat (4) @(negedge clk);
        slow_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_v[k] !== 23'd0) begin
                errors++; $display("FAIL reset[%0d]: got %h expected %h", k, act_v[k], 23'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        logic [15:0] bexp [4];
        bexp[0] = 16'h8000; bexp[1] = 16'hC000; bexp[2] = 16'hE000; bexp[3] = 16'hF000;
        pulse_start(1'b1);
        dcnt_a = 0; dcnt_b = 0;
        checks++;
        if (busy_a !== 1'b1 || step_a !== 5'd0) begin
            errors++; $display("FAIL fill_start: busy/step %b/%0d expected 1/0", busy_a, step_a);
        end
        for (int i = 1; i <= 16; i++) begin
            rise(1'b1);
            checks++;
            if (led_a !== 16'((32'd1 << i) - 32'd1) || step_a !== 5'(i)) begin
                errors++; $display("FAIL fill_a step %0d: led %h step %0d", i, led_a, step_a);
            end
            if (i <= 4) begin
                checks++;
                if (led_b !== bexp[i-1]) begin
                    errors++; $display("FAIL fill_b step %0d: led %h expected %h", i, led_b, bexp[i-1]);
                end
            end
            if (i == 15) begin
                checks++;
                if (busy_a !== 1'b1 || dcnt_a != 0) begin
                    errors++; $display("FAIL fill_busy15: busy %b dones %0d expected 1/0", busy_a, dcnt_a);
                end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++; $display("FAIL fill_model[%0d] step %0d: got %h expected %h", k, i, act_v[k], exp_v[k]);
                end
            end
        end
        checks++;
        if (dcnt_a != 1 || dcnt_b != 1) begin
            errors++; $display("FAIL fill_done_count: got %0d/%0d expected 1/1", dcnt_a, dcnt_b);
        end
        checks++;
        if (busy_a !== 1'b0 || step_a !== 5'd16 || led_a !== 16'hFFFF) begin
            errors++; $display("FAIL fill_final: busy %b step %0d led %h", busy_a, step_a, led_a);
        end
        checks++;
        if (step_b !== 5'd4 || led_b !== 16'hF000 || busy_b !== 1'b0) begin
            errors++; $display("FAIL fill_b_sat: step %0d led %h busy %b", step_b, led_b, busy_b);
        end
    endtask

    task automatic test_pause();
        pulse_start(1'b1);   // restart from DONE
        checks++;
        if (led_a !== 16'h0 || step_a !== 5'd0 || busy_a !== 1'b1) begin
            errors++; $display("FAIL restart_from_done: led %h step %0d busy %b", led_a, step_a, busy_a);
        end
        repeat (5) rise(1'b1);
        repeat (3) rise(1'b0);
        checks++;
        if (led_a !== 16'h001F || step_a !== 5'd5 || busy_a !== 1'b1) begin
            errors++; $display("FAIL pause_hold: led %h step %0d busy %b expected 001F/5/1", led_a, step_a, busy_a);
        end
        rise(1'b1);
        checks++;
        if (led_a !== 16'h003F || step_a !== 5'd6) begin
            errors++; $display("FAIL pause_resume: led %h step %0d expected 003F/6", led_a, step_a);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_v[k] !== exp_v[k]) begin
                errors++; $display("FAIL pause_model[%0d]: got %h expected %h", k, act_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        en = 1'b1; slow_clk = 1'b0;
        @(negedge clk);
        slow_clk = 1'b1;
        pulse_start(1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (step_a !== 5'd0 || busy_a !== 1'b1) begin
            errors++; $display("FAIL start_with_rise: step %0d busy %b expected 0/1", step_a, busy_a);
        end
        slow_clk = 1'b0;
        @(negedge clk);
        slow_clk = 1'b1; en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (step_a !== 5'd0 || led_a !== 16'h0) begin
            errors++; $display("FAIL en_fall_with_rise: step %0d led %h expected 0/0000", step_a, led_a);
        end
        repeat (7) rise(1'b1);
        pulse_start(1'b1);
        checks++;
        if (step_a !== 5'd7 || led_a !== 16'h007F || busy_a !== 1'b1) begin
            errors++; $display("FAIL start_in_run: step %0d led %h busy %b expected 7/007F/1", step_a, led_a, busy_a);
        end
        rise(1'b1);
        checks++;
        if (step_a !== 5'd8) begin
            errors++; $display("FAIL run_after_start: step %0d expected 8", step_a);
        end
    endtask

    task automatic test_held_high();
        @(negedge clk);
        rst_n = 1'b0; slow_clk = 1'b1; en = 1'b1; start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_v[k] !== 23'd0) begin
                errors++; $display("FAIL held_high_idle[%0d]: got %h expected 0", k, act_v[k]);
            end
        end
        pulse_start(1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (step_a !== 5'd0 || busy_a !== 1'b1) begin
            errors++; $display("FAIL held_high_run: step %0d busy %b expected 0/1", step_a, busy_a);
        end
        slow_clk = 1'b0;
        @(negedge clk);
        slow_clk = 1'b1;
        @(negedge clk);
        checks++;
        if (step_a !== 5'd1 || led_a !== 16'h0001) begin
            errors++; $display("FAIL held_high_edge: step %0d led %h expected 1/0001", step_a, led_a);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_start(1'b1);
        repeat (9) rise(1'b1);
        checks++;
        if (step_a !== 5'd9 || led_a !== 16'h01FF) begin
            errors++; $display("FAIL pre_abort: step %0d led %h expected 9/01FF", step_a, led_a);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_v[k] !== 23'd0) begin
                errors++; $display("FAIL async_abort[%0d]: got %h expected 0", k, act_v[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: done %b busy %b expected 0/0", done_a, busy_a);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (act_v[k] !== exp_v[k]) begin
                    errors++; $display("FAIL random[%0d] cycle %0d: got %h expected %h", k, i, act_v[k], exp_v[k]);
                end
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            start = ($urandom_range(0, 24) == 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) slow_clk = ~slow_clk;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_pause();
        test_same_cycle();
        test_held_high();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
